p_mem: RTL and testbench

P_MEM -- requirements
Module: p_mem

---
 rtl/p_mem_pkg.sv | 41 ++++
 rtl/p_mem_lane_asm.sv | 55 +++++
 rtl/p_mem.sv | 152 +++++++++++++++
 tb/tb_p_mem.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_mem_pkg.sv
// Shared codes for the MEM stage: instruction classes, load/store opcodes and FSM states.
// Consumers import p_mem_pkg::*.
package p_mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] IC_EMP = 3'd0;
  localparam logic [2:0] IC_ALU = 3'd1;
  localparam logic [2:0] IC_LAS = 3'd2;
  localparam logic [2:0] IC_BRA = 3'd3;

  localparam logic [4:0] INS_LB  = 5'd0;
  localparam logic [4:0] INS_LH  = 5'd1;
  localparam logic [4:0] INS_LW  = 5'd2;
  localparam logic [4:0] INS_LBU = 5'd3;
  localparam logic [4:0] INS_LHU = 5'd4;
  localparam logic [4:0] INS_SB  = 5'd5;
  localparam logic [4:0] INS_SH  = 5'd6;
  localparam logic [4:0] INS_SW  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_WAIT_LAST = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // Index of the final byte of an access (access width minus one).
  function automatic logic [1:0] last_byte(input logic [4:0] op);
    case (op)
      INS_LB, INS_LBU, INS_SB: last_byte = 2'd0;
      INS_LH, INS_LHU, INS_SH: last_byte = 2'd1;
      default:                 last_byte = 2'd3;
    endcase
  endfunction

  function automatic logic is_store(input logic [4:0] op);
    is_store = (op == INS_SB) || (op == INS_SH) || (op == INS_SW);
  endfunction

endpackage

// File: rtl/p_mem_lane_asm.sv
// Load byte-lane capture and sign/zero extension for the MEM stage.
// A byte returned during the first frozen cycle is parked so it survives an enable stall.
module p_mem_lane_asm
  import p_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        cap,
  input  logic [1:0]  sel,
  input  logic [7:0]  din,
  input  logic [4:0]  opcode,
  output logic [31:0] result
);

  logic [3:0][7:0] lanes;
  logic [7:0]      hold;
  logic            rdy_q;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [4:0] op);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (op)
      INS_LB:  extend = 32'(b);
      INS_LBU: extend = {24'd0, raw[7:0]};
      INS_LH:  extend = 32'(h);
      INS_LHU: extend = {16'd0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes <= '0;
      hold  <= '0;
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= rdy;
      if (!rdy && rdy_q)
        hold <= din;
      if (rdy) begin
        if (clr)
          lanes <= '0;
        else if (cap)
          lanes[sel] <= rdy_q ? din : hold;
      end
    end
  end

  assign result = extend(lanes, opcode);

endmodule

// File: rtl/p_mem.sv
// MEM stage: byte-serial load/store engine over an 8-bit RAM plus ALU write-back pass-through.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of issuing them.
module p_mem
  import p_mem_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [2:0]  inst_catagory,
  input  logic [4:0]  local_opcode,
  input  logic        we,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  input  logic [7:0]  ram_din,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  output logic        out_we,
  output logic [31:0] out_w_addr,
  output logic [31:0] out_w_data,
  output logic        busy_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [4:0]  op_q;
  logic [31:0] addr_q, data_q, waddr_q;
  logic        we_q, mis_q;
  logic [1:0]  last;
  logic        store, accept, mis_acc;
  logic        cap;
  logic [1:0]  sel;
  logic [31:0] asm_data;

  assign last   = last_byte(op_q);
  assign store  = is_store(op_q);
  assign accept = (state == ST_IDLE) && (inst_catagory == IC_LAS);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_acc = ((last_byte(local_opcode) == 2'd1) && mem_addr[0]) ||
                   ((last_byte(local_opcode) == 2'd3) && (mem_addr[1:0] != 2'd0));
`else
  assign mis_acc = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    busy_out  = accept || (state == ST_ACCESS) || (state == ST_WAIT_LAST);
    ram_a     = '0;
    ram_wr    = 1'b0;
    ram_dout  = '0;
    unique case (state)
      ST_IDLE:      if (accept) state_nxt = mis_acc ? ST_DONE : ST_ACCESS;
      ST_ACCESS:    if (k == last) state_nxt = store ? ST_DONE : ST_WAIT_LAST;
      ST_WAIT_LAST: state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (state == ST_ACCESS) begin
      ram_a = addr_q + {30'd0, k};
      if (store) begin
        ram_wr   = rdy_in;
        ram_dout = data_q[{k, 3'b000} +: 8];
      end
    end
  end

  // Control: state, byte counter and the latched request
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= ST_IDLE;
      k       <= 2'd0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else if (rdy_in) begin
      state <= state_nxt;
      if (state == ST_ACCESS)
        k <= (k == last) ? 2'd0 : k + 2'd1;
      else
        k <= 2'd0;
      if (accept) begin
        op_q    <= local_opcode;
        addr_q  <= mem_addr;
        data_q  <= store_data;
        waddr_q <= w_addr;
        we_q    <= we;
        mis_q   <= mis_acc;
      end
    end
  end

  // Lane k-1 is captured while byte k is issued; WAIT_LAST picks up the final lane.
  assign cap = ((state == ST_ACCESS) && (k != 2'd0) && !store) || (state == ST_WAIT_LAST);
  assign sel = (state == ST_WAIT_LAST) ? last : k - 2'd1;

  p_mem_lane_asm u_lane_asm (
    .clk    (clk_in),
    .rst    (rst_in),
    .rdy    (rdy_in),
    .clr    (accept),
    .cap    (cap),
    .sel    (sel),
    .din    (ram_din),
    .opcode (op_q),
    .result (asm_data)
  );

  // Write-back register to the MEM/WB latch
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_we     <= 1'b0;
      out_w_addr <= '0;
      out_w_data <= '0;
    end else if (rdy_in) begin
      if (state == ST_IDLE) begin
        if ((inst_catagory == IC_EMP) || (inst_catagory == IC_LAS)) begin
          out_we     <= 1'b0;
          out_w_addr <= '0;
          out_w_data <= '0;
        end else begin
          out_we     <= we;
          out_w_addr <= w_addr;
          out_w_data <= w_data;
        end
      end else if (state == ST_DONE) begin
        out_we     <= we_q && !store && !mis_q;
        out_w_addr <= waddr_q;
        out_w_data <= asm_data;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      misalign_err <= 1'b0;
    else if (rdy_in)
      misalign_err <= accept && mis_acc;
  end
`endif

endmodule

// File: tb/tb_p_mem.sv
// Directed scoreboard bench for p_mem with a registered byte-RAM model.
module tb_p_mem;
  import p_mem_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [2:0]  inst_catagory;
  logic [4:0]  local_opcode;
  logic        we;
  logic [31:0] w_addr, w_data, mem_addr, store_data;
  logic [7:0]  ram_din;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic        out_we;
  logic [31:0] out_w_addr, out_w_data;
  logic        busy_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  p_mem dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .inst_catagory (inst_catagory),
    .local_opcode  (local_opcode),
    .we            (we),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .mem_addr      (mem_addr),
    .store_data    (store_data),
    .ram_din       (ram_din),
    .ram_a         (ram_a),
    .ram_dout      (ram_dout),
    .ram_wr        (ram_wr),
    .out_we        (out_we),
    .out_w_addr    (out_w_addr),
    .out_w_data    (out_w_data),
    .busy_out      (busy_out)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic we; logic [31:0] a; logic [31:0] d; logic chk_d; } sb_t;

  logic [7:0]  mem [0:4095];
  wr_t         wr_log[$];
  wr_t         exp_wr[$];
  sb_t         sb[$];
  logic [31:0] tr_a [0:3];
  int          tests = 0;
  int          fails = 0;

  // Fold the few addresses used here into a small array without collisions.
  function automatic logic [11:0] midx(input logic [31:0] a);
    midx = a[11:0] ^ {a[17:16], 10'd0};
  endfunction

  // RAM: read data appears the cycle after the address; writes are logged for checking.
  always @(posedge clk_in) begin
    if (ram_wr) begin
      mem[midx(ram_a)] <= ram_dout;
      wr_log.push_back('{ram_a, ram_dout});
    end
    ram_din <= mem[midx(ram_a)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_catagory = IC_EMP;
    local_opcode  = '0;
    we            = 1'b0;
    w_addr        = '0;
    w_data        = '0;
    mem_addr      = '0;
    store_data    = '0;
  endtask

  task automatic do_alu(input logic [2:0] cat, input logic [31:0] wa, input logic [31:0] wd,
                        input logic exp_we, input logic [31:0] exp_a, input logic [31:0] exp_d);
    sb_t e;
    inst_catagory = cat;
    we            = 1'b1;
    w_addr        = wa;
    w_data        = wd;
    sb.push_back('{exp_we, exp_a, exp_d, 1'b1});
    #1;
    chk("alu_busy", 32'(busy_out), 32'd0);
    @(posedge clk_in); #1;
    e = sb.pop_front();
    chk("alu_we", 32'(out_we), 32'(e.we));
    chk("alu_waddr", out_w_addr, e.a);
    chk("alu_wdata", out_w_data, e.d);
    idle_inputs();
  endtask

  task automatic do_las(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] wa, input logic [31:0] exp_d, input int stall_at);
    int          n, cyc, exp_lat;
    logic        st, done;
    logic [31:0] held;
    sb_t         e;
    wr_t         w, x;
    case (op)
      INS_LB, INS_LBU, INS_SB: n = 1;
      INS_LH, INS_LHU, INS_SH: n = 2;
      default:                 n = 4;
    endcase
    st      = (op == INS_SB) || (op == INS_SH) || (op == INS_SW);
    exp_lat = n + (st ? 1 : 2) + ((stall_at > 0) ? 3 : 0);
    if (st)
      for (int i = 0; i < n; i++) exp_wr.push_back('{addr + 32'(i), sdata[8*i +: 8]});
    sb.push_back('{!st, wa, exp_d, !st});
    inst_catagory = IC_LAS;
    local_opcode  = op;
    mem_addr      = addr;
    store_data    = sdata;
    we            = 1'b1;
    w_addr        = wa;
    w_data        = 32'hDEAD_0000;
    #1;
    chk("las_busy", 32'(busy_out), 32'd1);
    cyc  = 0;
    done = 1'b0;
    held = '0;
    while (!done && cyc < 40) begin
      @(posedge clk_in); #1;
      cyc++;
      if (stall_at > 0 && cyc == stall_at) begin
        rdy_in = 1'b0;
        #1;
        chk("stall_wr", 32'(ram_wr), 32'd0);
        held = ram_a;
      end else if (stall_at > 0 && cyc > stall_at && cyc <= stall_at + 3) begin
        chk("stall_addr", ram_a, held);
        chk("stall_wr", 32'(ram_wr), 32'd0);
        if (cyc == stall_at + 3) rdy_in = 1'b1;
      end
      if (cyc <= 4) tr_a[cyc-1] = ram_a;
      if (!busy_out) done = 1'b1;
    end
    chk("las_done_seen", 32'(done), 32'd1);
    chk("las_latency", 32'(cyc), 32'(exp_lat));
    chk("done_ram_wr", 32'(ram_wr), 32'd0);
    chk("done_ram_a", ram_a, 32'd0);
    @(posedge clk_in); #1;
    e = sb.pop_front();
    chk("las_we", 32'(out_we), 32'(e.we));
    if (e.chk_d) begin
      chk("las_waddr", out_w_addr, e.a);
      chk("las_wdata", out_w_data, e.d);
    end
    idle_inputs();
    while (exp_wr.size() > 0) begin
      x = exp_wr.pop_front();
      chk("wr_present", 32'(wr_log.size() > 0), 32'd1);
      if (wr_log.size() > 0) begin
        w = wr_log.pop_front();
        chk("wr_addr", w.a, x.a);
        chk("wr_data", 32'(w.d), 32'(x.d));
      end
    end
    chk("wr_extra", 32'(wr_log.size()), 32'd0);
    wr_log.delete();
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle_inputs();
    #2;
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_out_waddr", out_w_addr, 32'd0);
    chk("rst_out_wdata", out_w_data, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    do_alu(IC_ALU, 32'd3, 32'd5, 1'b1, 32'd3, 32'd5);
    do_alu(IC_EMP, 32'd8, 32'd9, 1'b0, 32'd0, 32'd0);

    do_las(INS_SW, 32'h100, 32'h1122_3344, 32'd4, 32'd0, 0);
    do_las(INS_LW, 32'h100, 32'd0, 32'd5, 32'h1122_3344, 0);
    do_las(INS_SB, 32'h200, 32'h1234_5680, 32'd6, 32'd0, 0);
    do_las(INS_LB, 32'h200, 32'd0, 32'd7, 32'hFFFF_FF80, 0);
    do_las(INS_LBU, 32'h200, 32'd0, 32'd8, 32'h0000_0080, 0);
    do_las(INS_LH, 32'h102, 32'd0, 32'd9, 32'h0000_1122, 0);
    do_las(INS_LHU, 32'h100, 32'd0, 32'd10, 32'h0000_3344, 0);
    do_las(INS_SH, 32'h300, 32'h7777_BEEF, 32'd11, 32'd0, 0);
    do_las(INS_LH, 32'h300, 32'd0, 32'd12, 32'hFFFF_BEEF, 0);
    do_las(INS_LHU, 32'h300, 32'd0, 32'd13, 32'h0000_BEEF, 0);

    do_las(INS_SB, 32'hFFFF_FFFF, 32'h0000_00AB, 32'd14, 32'd0, 0);
    do_las(INS_SB, 32'h0000_0000, 32'h0000_00CD, 32'd15, 32'd0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    inst_catagory = IC_LAS;
    local_opcode  = INS_LH;
    mem_addr      = 32'hFFFF_FFFF;
    we            = 1'b1;
    w_addr        = 32'd16;
    @(posedge clk_in); #1;
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_ram_wr", 32'(ram_wr), 32'd0);
    chk("mis_ram_a", ram_a, 32'd0);
    @(posedge clk_in); #1;
    chk("mis_we", 32'(out_we), 32'd0);
    chk("mis_err_pulse", 32'(misalign_err), 32'd0);
    idle_inputs();
    chk("mis_no_wr", 32'(wr_log.size()), 32'd0);
`else
    do_las(INS_LH, 32'hFFFF_FFFF, 32'd0, 32'd16, 32'hFFFF_CDAB, 0);
    chk("wrap_a0", tr_a[0], 32'hFFFF_FFFF);
    chk("wrap_a1", tr_a[1], 32'h0000_0000);
`endif

    do_las(INS_SW, 32'h3_0000, 32'hA55A_3CC3, 32'd17, 32'd0, 0);
    do_las(INS_LW, 32'h3_0000, 32'd0, 32'd18, 32'hA55A_3CC3, 0);

    do_las(INS_LW, 32'h100, 32'd0, 32'd19, 32'h1122_3344, 2);
    do_las(INS_SW, 32'h100, 32'hCAFE_F00D, 32'd20, 32'd0, 1);
    do_las(INS_LW, 32'h100, 32'd0, 32'd21, 32'hCAFE_F00D, 0);

    // Reset lands while the third byte of a word load is on the bus.
    inst_catagory = IC_LAS;
    local_opcode  = INS_LW;
    mem_addr      = 32'h100;
    we            = 1'b1;
    w_addr        = 32'd22;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    chk("mid_lw_a", ram_a, 32'h102);
    rst_in = 1'b1;
    #1;
    chk("arst_ram_a", ram_a, 32'd0);
    chk("arst_ram_wr", 32'(ram_wr), 32'd0);
    chk("arst_out_we", 32'(out_we), 32'd0);
    chk("arst_out_wdata", out_w_data, 32'd0);
    inst_catagory = IC_ALU;
    we            = 1'b1;
    w_addr        = 32'd9;
    w_data        = 32'h77;
    @(posedge clk_in); #1;
    chk("arst_hold_we", 32'(out_we), 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    chk("post_rst_we", 32'(out_we), 32'd1);
    chk("post_rst_waddr", out_w_addr, 32'd9);
    chk("post_rst_wdata", out_w_data, 32'h77);
    chk("post_rst_busy", 32'(busy_out), 32'd0);
    idle_inputs();
    @(posedge clk_in); #1;

    do_las(INS_LW, 32'h100, 32'd0, 32'd23, 32'hCAFE_F00D, 0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
